// File: rtl/add_round_key_par.sv
// add_round_key_par: AddRoundKey engine for the AES encrypt datapath.
// Walks the NB state columns held in an external dual-port state RAM and
// XORs in the key bytes for round n from an external 2-port key RAM.
// Each column takes four cycles: CHECK and RD_B read two rows each, and
// WR_A and WR_B write back two rows each. The block uses an
// ap_start/ap_done/ap_idle/ap_ready handshake. Round indices that are out
// of range end the run at once with ap_err and do not touch either RAM.
module add_round_key_par #(
    parameter int NB         = 4,
    parameter int DATA_W     = 32,
    parameter int KEY_W      = 8,
    parameter int KEY_STRIDE = 120,
    parameter int ROUND_W    = 6,
    parameter int SA_W       = 5,
    parameter int KA_W       = 9
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic                ap_err,
    input  logic [ROUND_W-1:0]  n,
    output logic [SA_W-1:0]     statemt_address0,
    output logic                statemt_ce0,
    output logic                statemt_we0,
    output logic [DATA_W-1:0]   statemt_d0,
    input  logic [DATA_W-1:0]   statemt_q0,
    output logic [SA_W-1:0]     statemt_address1,
    output logic                statemt_ce1,
    output logic                statemt_we1,
    output logic [DATA_W-1:0]   statemt_d1,
    input  logic [DATA_W-1:0]   statemt_q1,
    output logic [KA_W-1:0]     key_address0,
    output logic                key_ce0,
    input  logic [KEY_W-1:0]    key_q0,
    output logic [KA_W-1:0]     key_address1,
    output logic                key_ce1,
    input  logic [KEY_W-1:0]    key_q1
);

    localparam int          MAX_ROUND    = KEY_STRIDE / NB - 1;
    localparam int          J_W          = $clog2(NB + 1);
    localparam logic [31:0] MAX_ROUND_U  = 32'(MAX_ROUND);
    localparam logic [31:0] STRIDE_1     = 32'(KEY_STRIDE);
    localparam logic [31:0] STRIDE_2     = 32'(2 * KEY_STRIDE);
    localparam logic [31:0] STRIDE_3     = 32'(3 * KEY_STRIDE);
    localparam logic [31:0] NB_U         = 32'(NB);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        CHECK = 5'b00010,
        RD_B  = 5'b00100,
        WR_A  = 5'b01000,
        WR_B  = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] n_q, n_d;
    logic               err_q, err_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [DATA_W-1:0]  xa_q, xa_d;
    logic [DATA_W-1:0]  xb_q, xb_d;

    logic [31:0]        col_base;
    logic [31:0]        key_base;
    logic               done_cond;

    // Base addresses of the current column in the state RAM and key table.
    always_comb begin
        col_base = 32'(j_q) << 2;
        key_base = 32'(n_q) * NB_U + 32'(j_q);
    end

    assign done_cond = err_q || (j_q == J_W'(NB));

    // Next-state logic. xa/xb hold the XOR results for the pair of rows
    // that is about to be written back.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        err_d   = err_q;
        j_d     = j_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    n_d     = n;
                    err_d   = (32'(n) > MAX_ROUND_U);
                    j_d     = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = done_cond ? IDLE : RD_B;
            end
            RD_B: begin
                xa_d    = statemt_q0 ^ DATA_W'(key_q0);
                xb_d    = statemt_q1 ^ DATA_W'(key_q1);
                state_d = WR_A;
            end
            WR_A: begin
                xa_d    = statemt_q0 ^ DATA_W'(key_q0);
                xb_d    = statemt_q1 ^ DATA_W'(key_q1);
                state_d = WR_B;
            end
            WR_B: begin
                j_d     = j_q + J_W'(1);
                state_d = CHECK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and RAM port decode. Every enable is low outside its active states.
    always_comb begin
        ap_done          = 1'b0;
        ap_ready         = 1'b0;
        ap_err           = 1'b0;
        ap_idle          = (state_q == IDLE) && !ap_start;
        statemt_address0 = '0;
        statemt_address1 = '0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = '0;
        statemt_d1       = '0;
        key_address0     = '0;
        key_address1     = '0;
        key_ce0          = 1'b0;
        key_ce1          = 1'b0;
        case (state_q)
            CHECK: begin
                if (done_cond) begin
                    ap_done  = 1'b1;
                    ap_ready = 1'b1;
                    ap_err   = err_q;
                end else begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_address0 = SA_W'(col_base);
                    statemt_address1 = SA_W'(col_base + 32'd1);
                    key_ce0          = 1'b1;
                    key_ce1          = 1'b1;
                    key_address0     = KA_W'(key_base);
                    key_address1     = KA_W'(key_base + STRIDE_1);
                end
            end
            RD_B: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = SA_W'(col_base + 32'd2);
                statemt_address1 = SA_W'(col_base + 32'd3);
                key_ce0          = 1'b1;
                key_ce1          = 1'b1;
                key_address0     = KA_W'(key_base + STRIDE_2);
                key_address1     = KA_W'(key_base + STRIDE_3);
            end
            WR_A: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = SA_W'(col_base);
                statemt_address1 = SA_W'(col_base + 32'd1);
                statemt_d0       = xa_q;
                statemt_d1       = xb_q;
            end
            WR_B: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = SA_W'(col_base + 32'd2);
                statemt_address1 = SA_W'(col_base + 32'd3);
                statemt_d0       = xa_q;
                statemt_d1       = xb_q;
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous reset. A reset mid-run drops straight back to IDLE.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            err_q   <= 1'b0;
            j_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            err_q   <= err_d;
            j_q     <= j_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
        end
    end

endmodule

// File: tb/tb_add_round_key_par.sv
// tb_add_round_key_par: directed bench for add_round_key_par.
// Two instances are tested: one with the default parameters and one
// 8-column build. Each instance has its own behavioural state RAM, and
// each key RAM returns address[7:0] with one cycle of latency.
module tb_add_round_key_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- default-parameter instance ----------------
    logic        rst_a, start_a, done_a, idle_a, ready_a, err_a;
    logic [5:0]  n_a;
    logic [4:0]  sa_a0, sa_a1;
    logic        ce_a0, ce_a1, we_a0, we_a1;
    logic [31:0] d_a0, d_a1, q_a0, q_a1;
    logic [8:0]  ka_a0, ka_a1;
    logic        kce_a0, kce_a1;
    logic [7:0]  kq_a0, kq_a1;

    add_round_key_par dut_a (
        .ap_clk(clk), .ap_rst(rst_a), .ap_start(start_a), .ap_done(done_a),
        .ap_idle(idle_a), .ap_ready(ready_a), .ap_err(err_a), .n(n_a),
        .statemt_address0(sa_a0), .statemt_ce0(ce_a0), .statemt_we0(we_a0),
        .statemt_d0(d_a0), .statemt_q0(q_a0),
        .statemt_address1(sa_a1), .statemt_ce1(ce_a1), .statemt_we1(we_a1),
        .statemt_d1(d_a1), .statemt_q1(q_a1),
        .key_address0(ka_a0), .key_ce0(kce_a0), .key_q0(kq_a0),
        .key_address1(ka_a1), .key_ce1(kce_a1), .key_q1(kq_a1)
    );

    // ---------------- 8-column instance ----------------
    logic        rst_b, start_b, done_b, idle_b, ready_b, err_b;
    logic [5:0]  n_b;
    logic [4:0]  sa_b0, sa_b1;
    logic        ce_b0, ce_b1, we_b0, we_b1;
    logic [31:0] d_b0, d_b1, q_b0, q_b1;
    logic [9:0]  ka_b0, ka_b1;
    logic        kce_b0, kce_b1;
    logic [7:0]  kq_b0, kq_b1;

    add_round_key_par #(.NB(8), .KEY_STRIDE(240), .SA_W(5), .KA_W(10)) dut_b (
        .ap_clk(clk), .ap_rst(rst_b), .ap_start(start_b), .ap_done(done_b),
        .ap_idle(idle_b), .ap_ready(ready_b), .ap_err(err_b), .n(n_b),
        .statemt_address0(sa_b0), .statemt_ce0(ce_b0), .statemt_we0(we_b0),
        .statemt_d0(d_b0), .statemt_q0(q_b0),
        .statemt_address1(sa_b1), .statemt_ce1(ce_b1), .statemt_we1(we_b1),
        .statemt_d1(d_b1), .statemt_q1(q_b1),
        .key_address0(ka_b0), .key_ce0(kce_b0), .key_q0(kq_b0),
        .key_address1(ka_b1), .key_ce1(kce_b1), .key_q1(kq_b1)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [32];
    logic        init_mem = 1'b0;
    int          acc_a = 0;
    logic        saw_119 = 1'b0;
    logic        saw_479 = 1'b0;

    // State RAMs (read-first, 1-cycle latency) and key RAMs returning address[7:0].
    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 16; k++) mem_a[k] <= 32'(k);
            for (int k = 0; k < 32; k++) mem_b[k] <= 32'(k);
            acc_a   <= 0;
            saw_119 <= 1'b0;
            saw_479 <= 1'b0;
        end else begin
            if (ce_a0) begin
                if (we_a0) mem_a[sa_a0[3:0]] <= d_a0;
                else       q_a0 <= mem_a[sa_a0[3:0]];
            end
            if (ce_a1) begin
                if (we_a1) mem_a[sa_a1[3:0]] <= d_a1;
                else       q_a1 <= mem_a[sa_a1[3:0]];
            end
            if (ce_b0) begin
                if (we_b0) mem_b[sa_b0] <= d_b0;
                else       q_b0 <= mem_b[sa_b0];
            end
            if (ce_b1) begin
                if (we_b1) mem_b[sa_b1] <= d_b1;
                else       q_b1 <= mem_b[sa_b1];
            end
            if (ce_a0 || ce_a1 || kce_a0 || kce_a1) acc_a <= acc_a + 1;
            if (kce_a0 && ka_a0 == 9'd119) saw_119 <= 1'b1;
            if (kce_a1 && ka_a1 == 9'd479) saw_479 <= 1'b1;
        end
        if (kce_a0) kq_a0 <= ka_a0[7:0];
        if (kce_a1) kq_a1 <= ka_a1[7:0];
        if (kce_b0) kq_b0 <= ka_b0[7:0];
        if (kce_b1) kq_b1 <= ka_b1[7:0];
    end

    // Reference key byte: low 8 bits of row*stride + n*nb + col.
    function automatic logic [31:0] keyByte(input int row, input int nv, input int col,
                                            input int nb, input int stride);
        return 32'((row * stride + nv * nb + col) % 256);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic initMem();
        @(negedge clk);
        init_mem = 1'b1;
        @(negedge clk);
        init_mem = 1'b0;
    endtask

    // Starts instance A with round nv and returns the done cycle relative to the accept cycle.
    task automatic applyStimulus(input logic [5:0] nv, output int done_cyc, output logic err_seen);
        @(negedge clk);
        n_a      = nv;
        start_a  = 1'b1;
        done_cyc = -1;
        err_seen = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                start_a = 1'b0;
                n_a     = 6'h3F;
            end
            if (done_a) begin
                done_cyc = c;
                err_seen = err_a;
                break;
            end
        end
    endtask

    task automatic applyStimulusWide(input logic [5:0] nv, output int done_cyc, output logic err_seen);
        @(negedge clk);
        n_b      = nv;
        start_b  = 1'b1;
        done_cyc = -1;
        err_seen = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            if (done_b) begin
                done_cyc = c;
                err_seen = err_b;
                break;
            end
        end
    endtask

    // Directed sequence of all test steps.
    initial begin
        int   cyc;
        int   d1;
        int   d2;
        logic e;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        n_a = '0; n_b = '0;
        q_a0 = '0; q_a1 = '0; q_b0 = '0; q_b1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_ready", 32'(ready_a), 32'd0);
        checkOutput("rst_err", 32'(err_a), 32'd0);
        checkOutput("rst_enables", 32'({ce_a0, ce_a1, we_a0, we_a1, kce_a0, kce_a1}), 32'd0);
        checkOutput("rst_idle", 32'(idle_a), 32'd1);
        start_a = 1'b1;
        #1;
        checkOutput("rst_idle_start_hi", 32'(idle_a), 32'd0);
        start_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // n=1 with hand-computed column 0
        initMem();
        applyStimulus(6'd1, cyc, e);
        checkOutput("n1_done_cycle", 32'(cyc), 32'd17);
        checkOutput("n1_err", 32'(e), 32'd0);
        checkOutput("n1_state0", mem_a[0], 32'h04);
        checkOutput("n1_state1", mem_a[1], 32'h7D);
        checkOutput("n1_state2", mem_a[2], 32'hF6);
        checkOutput("n1_state3", mem_a[3], 32'h6F);
        for (int k = 4; k < 16; k++)
            checkOutput($sformatf("n1_state%0d", k), mem_a[k],
                        32'(k) ^ keyByte(k % 4, 1, k / 4, 4, 120));

        // n=29 is the last legal round
        initMem();
        applyStimulus(6'd29, cyc, e);
        checkOutput("n29_done_cycle", 32'(cyc), 32'd17);
        checkOutput("n29_err", 32'(e), 32'd0);
        checkOutput("n29_key119_seen", 32'(saw_119), 32'd1);
        checkOutput("n29_key479_seen", 32'(saw_479), 32'd1);
        checkOutput("n29_state12", mem_a[12], 32'h7B);
        checkOutput("n29_state15", mem_a[15], 32'hD0);

        // n=30 is rejected without touching memory
        initMem();
        applyStimulus(6'd30, cyc, e);
        checkOutput("n30_done_cycle", 32'(cyc), 32'd1);
        checkOutput("n30_err", 32'(e), 32'd1);
        checkOutput("n30_accesses", 32'(acc_a), 32'd0);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("n30_state%0d", k), mem_a[k], 32'(k));

        // Reset during WR_A of column 1
        initMem();
        @(negedge clk);
        n_a = 6'd1;
        start_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
        end
        checkOutput("mid_rst_wr_a", 32'({we_a0, sa_a0}), 32'({1'b1, 5'd4}));
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        checkOutput("mid_rst_idle", 32'(idle_a), 32'd1);
        checkOutput("mid_rst_enables", 32'({ce_a0, ce_a1, we_a0, we_a1, kce_a0, kce_a1}), 32'd0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("mid_rst_state%0d", k), mem_a[k],
                        (k < 6) ? (32'(k) ^ keyByte(k % 4, 1, k / 4, 4, 120)) : 32'(k));
        initMem();
        applyStimulus(6'd1, cyc, e);
        checkOutput("post_rst_done_cycle", 32'(cyc), 32'd17);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("post_rst_state%0d", k), mem_a[k],
                        32'(k) ^ keyByte(k % 4, 1, k / 4, 4, 120));

        // Back-to-back runs with ap_start held high: n=0 then n=1
        initMem();
        @(negedge clk);
        n_a = 6'd0;
        start_a = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) n_a = 6'd1;
            if (d1 > 0 && c == d1 + 2) start_a = 1'b0;
            if (done_a) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    break;
                end
            end
        end
        start_a = 1'b0;
        checkOutput("b2b_first_done", 32'(d1), 32'd17);
        checkOutput("b2b_spacing", 32'(d2 - d1), 32'd18);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("b2b_state%0d", k), mem_a[k],
                        32'(k) ^ keyByte(k % 4, 0, k / 4, 4, 120) ^ keyByte(k % 4, 1, k / 4, 4, 120));

        // 8-column build, n=2
        initMem();
        applyStimulusWide(6'd2, cyc, e);
        checkOutput("nb8_done_cycle", 32'(cyc), 32'd33);
        checkOutput("nb8_err", 32'(e), 32'd0);
        checkOutput("nb8_state0", mem_b[0], 32'h10);
        checkOutput("nb8_state31", mem_b[31], 32'hF8);
        for (int k = 1; k < 31; k++)
            checkOutput($sformatf("nb8_state%0d", k), mem_b[k],
                        32'(k) ^ keyByte(k % 4, 2, k / 4, 8, 240));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
